// File: rtl/sprite_overlay_engine.sv
// sprite_overlay_engine
//   Overlays N_SPR icon channels on the scaled logical pixel grid and merges
//   them, by priority, into a single colour code for the colorizer.
//   Each channel compares the current logical pixel against its frame-latched
//   top-left corner. On a hit it registers an icon ROM address computed from the
//   pixel offset. The hit flags are delayed to line up with the external ROM
//   data. The lowest-index channel with non-transparent data wins.
//   Latency from vid_row/vid_col to sprite_px is ROM_LAT+2 clocks.
// Ports
//   i_clk, i_reset_n            clock, async active-low reset
//   i_vid_row, i_vid_col        current video pixel (10b each)
//   i_loc_x, i_loc_y            per-channel logical top-left, ch i = [8i+7:8i]
//   i_spr_en, i_spr_blink       per-channel enable / blink request
//   o_rom_addr                  per-channel icon ROM address (registered)
//   i_rom_data                  per-channel ROM data, ROM_LAT clocks after addr
//   o_sprite_px/hit/id          merged colour code, non-transparent flag, winner

// One sprite channel: window compare plus address generation (S0 -> S1).
module sprite_chan #(
  parameter int SPR_W = 14,
  parameter int SPR_H = 14,
  parameter int AW    = 8
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [7:0]    i_pc,
  input  logic [7:0]    i_pr,
  input  logic [7:0]    i_lx,
  input  logic [7:0]    i_ly,
  input  logic          i_vis,
  output logic [AW-1:0] o_addr,
  output logic          o_hit
);
  logic [8:0]    w_x_hi, w_y_hi;
  logic [7:0]    w_dx, w_dy;
  logic          w_hit;
  logic [AW-1:0] w_addr;

  // Upper bounds in 9 bits: a sprite near 255 is clipped instead of wrapping to 0.
  assign w_x_hi = {1'b0, i_lx} + 9'(SPR_W - 1);
  assign w_y_hi = {1'b0, i_ly} + 9'(SPR_H - 1);
  assign w_hit  = i_vis && (i_pc >= i_lx) && ({1'b0, i_pc} <= w_x_hi)
                        && (i_pr >= i_ly) && ({1'b0, i_pr} <= w_y_hi);
  assign w_dx   = i_pc - i_lx;
  assign w_dy   = i_pr - i_ly;
  assign w_addr = AW'(w_dy * SPR_W + w_dx);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_addr <= '0;
      o_hit  <= 1'b0;
    end else begin
      o_addr <= w_hit ? w_addr : '0;
      o_hit  <= w_hit;
    end
  end
endmodule

module sprite_overlay_engine #(
  parameter int N_SPR    = 2,
  parameter int SPR_W    = 14,
  parameter int SPR_H    = 14,
  parameter int SCALE_SH = 2,
  parameter int CW       = 3,
  parameter int ROM_LAT  = 1,
  parameter int BLINK_FR = 16,
  localparam int AW      = $clog2(SPR_W * SPR_H),
  localparam int IW      = (N_SPR > 1) ? $clog2(N_SPR) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [9:0]          i_vid_row,
  input  logic [9:0]          i_vid_col,
  input  logic [N_SPR*8-1:0]  i_loc_x,
  input  logic [N_SPR*8-1:0]  i_loc_y,
  input  logic [N_SPR-1:0]    i_spr_en,
  input  logic [N_SPR-1:0]    i_spr_blink,
  output logic [N_SPR*AW-1:0] o_rom_addr,
  input  logic [N_SPR*CW-1:0] i_rom_data,
  output logic [CW-1:0]       o_sprite_px,
  output logic                o_sprite_hit,
  output logic [IW-1:0]       o_sprite_id
);
  localparam int FCW = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;

  logic                      w_at0, w_fs, r_at0;
  logic [N_SPR-1:0][7:0]     r_lx, r_ly;
  logic [N_SPR-1:0]          r_en, r_blink;
  logic [FCW-1:0]            r_frame_cnt;
  logic                      r_blink_ph;
  logic [7:0]                w_pc, w_pr;
  logic [N_SPR-1:0][AW-1:0]  w_addr;
  logic [N_SPR-1:0]          w_hit_s1;
  logic [ROM_LAT:1][N_SPR-1:0] r_hit_dly;
  logic [N_SPR-1:0][CW-1:0]  w_data;
  logic [CW-1:0]             w_px;
  logic [IW-1:0]             w_id;
  logic                      w_win;

  // Frame start fires once on entry to pixel 0/0; holding 0/0 does not re-fire.
  assign w_at0 = (i_vid_row == 10'd0) && (i_vid_col == 10'd0);
  assign w_fs  = w_at0 && !r_at0;

  // Shadow state only moves at frame start so positions never tear mid-frame.
  // Reset clears enables, so nothing shows until the first frame start.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_at0       <= 1'b0;
      r_lx        <= '0;
      r_ly        <= '0;
      r_en        <= '0;
      r_blink     <= '0;
      r_frame_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else begin
      r_at0 <= w_at0;
      if (w_fs) begin
        r_lx    <= i_loc_x;
        r_ly    <= i_loc_y;
        r_en    <= i_spr_en;
        r_blink <= i_spr_blink;
        if (r_frame_cnt == FCW'(BLINK_FR - 1)) begin
          r_frame_cnt <= '0;
          r_blink_ph  <= ~r_blink_ph;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  assign w_pc = 8'(i_vid_col >> SCALE_SH);
  assign w_pr = 8'(i_vid_row >> SCALE_SH);

  for (genvar g = 0; g < N_SPR; g++) begin : g_chan
    sprite_chan #(.SPR_W(SPR_W), .SPR_H(SPR_H), .AW(AW)) u_chan (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_pc      (w_pc),
      .i_pr      (w_pr),
      .i_lx      (r_lx[g]),
      .i_ly      (r_ly[g]),
      .i_vis     (r_en[g] && !(r_blink[g] && r_blink_ph)),
      .o_addr    (w_addr[g]),
      .o_hit     (w_hit_s1[g])
    );
  end

  assign o_rom_addr = w_addr;
  assign w_data     = i_rom_data;

  // Hit flags ride alongside the ROM read so they meet the returning data.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_hit_dly <= '0;
    end else begin
      r_hit_dly[1] <= w_hit_s1;
      for (int k = 2; k <= ROM_LAT; k++) r_hit_dly[k] <= r_hit_dly[k-1];
    end
  end

  // Scan high to low so the lowest-index opaque channel is the last writer.
  always_comb begin
    w_px  = '0;
    w_id  = '0;
    w_win = 1'b0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (r_hit_dly[ROM_LAT][i] && (w_data[i] != '0)) begin
        w_px  = w_data[i];
        w_id  = IW'(i);
        w_win = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_sprite_px  <= '0;
      o_sprite_hit <= 1'b0;
      o_sprite_id  <= '0;
    end else begin
      o_sprite_px  <= w_px;
      o_sprite_hit <= w_win;
      o_sprite_id  <= w_id;
    end
  end
endmodule

// File: tb/tb_sprite_overlay_engine.sv
// Bench for sprite_overlay_engine: directed pixels, expected responses queued
// at drive time and checked by an independent monitor when they come due.
module tb_sprite_overlay_engine;
  localparam int N_SPR = 2, CW = 3, AW = 8, IW = 1;

  logic                i_clk = 1'b0, i_reset_n = 1'b0;
  logic [9:0]          vid_row, vid_col;
  logic [N_SPR*8-1:0]  loc_x, loc_y;
  logic [N_SPR-1:0]    en, blink;
  logic [N_SPR*AW-1:0] rom_addr;
  logic [N_SPR*CW-1:0] rom_data = '0;
  logic [CW-1:0]       px;
  logic                hit;
  logic [IW-1:0]       id;

  always #5 i_clk = ~i_clk;

  sprite_overlay_engine dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_vid_row(vid_row), .i_vid_col(vid_col),
    .i_loc_x(loc_x), .i_loc_y(loc_y), .i_spr_en(en), .i_spr_blink(blink),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_sprite_px(px), .o_sprite_hit(hit), .o_sprite_id(id));

  // Icon ROM model, latency 1. ch0 = addr[2:0]^5 (blankable), ch1 = addr[2:0]^2.
  logic rom0_blank = 1'b0;
  always @(posedge i_clk) begin
    rom_data[2:0] <= rom0_blank ? 3'd0 : (rom_addr[2:0] ^ 3'd5);
    rom_data[5:3] <= rom_addr[10:8] ^ 3'd2;
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct { int due; bit chk; logic [15:0] addr; string nm; } a_t;
  typedef struct { int due; bit chk; logic [2:0] px; logic hit; logic id; string nm; } p_t;
  a_t qa[$];
  p_t qp[$];

  always @(negedge i_clk) begin : mon
    a_t ea;
    p_t ep;
    while (qa.size() > 0 && qa[0].due <= cyc) begin
      ea = qa.pop_front();
      if (ea.chk) check({ea.nm, "_addr"}, rom_addr, ea.addr);
    end
    while (qp.size() > 0 && qp[0].due <= cyc) begin
      ep = qp.pop_front();
      if (ep.chk) begin
        check({ep.nm, "_px"}, px, ep.px);
        check({ep.nm, "_hit"}, hit, ep.hit);
        check({ep.nm, "_id"}, id, ep.id);
      end
    end
  end

  task automatic drv(input int col, input int row, input bit c, input logic [7:0] a0,
                     input logic [7:0] a1, input logic [2:0] p, input logic h,
                     input logic i, input string nm);
    a_t ea;
    p_t ep;
    @(posedge i_clk); #1;
    vid_col = 10'(col);
    vid_row = 10'(row);
    ea.due = cyc + 1; ea.chk = c; ea.addr = {a1, a0}; ea.nm = nm;
    ep.due = cyc + 3; ep.chk = c; ep.px = p; ep.hit = h; ep.id = i; ep.nm = nm;
    qa.push_back(ea);
    qp.push_back(ep);
  endtask

  // Logical pixel with non-zero sub-pixel bits, so the scale shift is exercised.
  task automatic lp(input int pc, input int pr, input logic [7:0] a0, input logic [7:0] a1,
                    input logic [2:0] p, input logic h, input logic i, input string nm);
    drv(pc * 4 + 3, pr * 4 + 1, 1'b1, a0, a1, p, h, i, nm);
  endtask

  task automatic miss(input int pc, input int pr, input string nm);
    lp(pc, pr, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0, nm);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drv(4, 4, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0, "idle");
  endtask

  task automatic frame_start();
    drv(0, 0, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0, "fs");
    drv(4, 4, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0, "fs");
  endtask

  task automatic set_loc(input int ch, input int x, input int y);
    loc_x[ch*8 +: 8] = 8'(x);
    loc_y[ch*8 +: 8] = 8'(y);
  endtask

  task automatic wait_drain(input string nm);
    for (int k = 0; k < 20 && (qa.size() != 0 || qp.size() != 0); k++) @(negedge i_clk);
    check(nm, qa.size() + qp.size(), 0);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_addr"}, rom_addr, 0);
    check({nm, "_px"}, px, 0);
    check({nm, "_hit"}, hit, 0);
    check({nm, "_id"}, id, 0);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    logic vis;
    vid_row = 10'd5; vid_col = 10'd5;
    loc_x = '0; loc_y = '0; en = '0; blink = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check_zero("reset");
    i_reset_n = 1'b1;

    // Basic window, address and edges of ch0 at (10,20)
    set_loc(0, 10, 20); en = 2'b01;
    frame_start();
    lp(10, 20, 8'd0,   8'd0, 3'd5, 1'b1, 1'b0, "t1_topleft");
    lp(11, 20, 8'd1,   8'd0, 3'd4, 1'b1, 1'b0, "t1_x1");
    lp(15, 20, 8'd5,   8'd0, 3'd0, 1'b0, 1'b0, "t1_transparent");
    lp(23, 33, 8'd195, 8'd0, 3'd6, 1'b1, 1'b0, "t2_botright");
    lp(10, 33, 8'd182, 8'd0, 3'd3, 1'b1, 1'b0, "t2_botleft");
    miss(24, 33, "t2_right_out");
    miss(23, 34, "t2_below_out");
    miss(9, 20, "t2_left_out");
    miss(10, 19, "t2_above_out");

    // Mid-frame move is deferred to the next frame start
    set_loc(0, 100, 20);
    lp(10, 20, 8'd0, 8'd0, 3'd5, 1'b1, 1'b0, "t3_old_pos_held");
    miss(100, 20, "t3_new_pos_early");
    frame_start();
    miss(10, 20, "t3_old_pos_gone");
    lp(100, 20, 8'd0, 8'd0, 3'd5, 1'b1, 1'b0, "t3_new_pos");

    // Overlap at (43,43): ch0 offset (0,0), ch1 offset (13,13)
    set_loc(0, 43, 43); set_loc(1, 30, 30); en = 2'b11;
    frame_start();
    lp(43, 43, 8'd0, 8'd195, 3'd5, 1'b1, 1'b0, "t4_overlap_ch0");
    lp(30, 30, 8'd0, 8'd0,   3'd2, 1'b1, 1'b1, "t4_ch1_only");
    lp(50, 43, 8'd7, 8'd0,   3'd2, 1'b1, 1'b0, "t4_ch0_only");
    idle(3);
    rom0_blank = 1'b1;
    lp(43, 43, 8'd0, 8'd195, 3'd1, 1'b1, 1'b1, "t4_ch0_transparent");
    idle(3);
    wait_drain("t4_drain");
    rom0_blank = 1'b0;

    // Blink: restart frame count, ch1 blinks, ch0 steady
    i_reset_n = 1'b0;
    set_loc(0, 100, 100); set_loc(1, 10, 10); en = 2'b11; blink = 2'b10;
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      frame_start();
      vis = (k < 16) || (k >= 32);
      lp(10, 10, 8'd0, 8'd0, vis ? 3'd2 : 3'd0, vis, vis, $sformatf("t5_blink_f%0d", k));
      lp(100, 100, 8'd0, 8'd0, 3'd5, 1'b1, 1'b0, $sformatf("t5_steady_f%0d", k));
    end

    // Right-edge clipping at loc_x=250
    set_loc(0, 250, 10); en = 2'b01; blink = 2'b00;
    frame_start();
    lp(250, 10, 8'd0,  8'd0, 3'd5, 1'b1, 1'b0, "t6_x250");
    lp(254, 10, 8'd4,  8'd0, 3'd1, 1'b1, 1'b0, "t6_x254");
    lp(255, 11, 8'd19, 8'd0, 3'd6, 1'b1, 1'b0, "t6_x255");
    for (int pc = 0; pc < 8; pc++) miss(pc, 10, $sformatf("t6_nowrap_pc%0d", pc));

    // Reset mid-line while the sprite is on screen
    repeat (3) drv(250 * 4 + 3, 41, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0, "pre");
    wait_drain("t6_drain");
    check("t6_pre_reset_hit", hit, 1);
    @(posedge i_clk); #3;
    i_reset_n = 1'b0;
    #1;
    check_zero("t6_async_reset");
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    miss(250, 10, "t6_hidden_after_reset");
    frame_start();
    lp(250, 10, 8'd0, 8'd0, 3'd5, 1'b1, 1'b0, "t6_reappear");

    wait_drain("final_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
